// File: rtl/rv_mem_defs.sv
// Shared definitions for the load/store controller.
//   - default geometry of data_memory (word-address bits, data width)
//   - RV32I funct3 encodings for loads and stores
//   - controller FSM state encoding
package rv_mem_defs;

    localparam int unsigned N_ADDR_DEF = 8;
    localparam int unsigned N_BIT_DEF  = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StCap,
        StWr,
        StResp
    } lsu_state_e;

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Core-request / memory bus bundle of the load/store controller.
//   master: the controller (accepts core requests, initiates memory accesses)
//   slave : the environment (core execute stage plus data_memory)
// Core side  : Req_valid/Req_ready/Req_we/Funct3/Byte_addr/Store_data,
//              Resp_valid/Resp_err/Load_data
// Memory side: Addr/Wr_data/MemRead/MemWrite/Rd_data
interface lsu_mem_ctrl_if import rv_mem_defs::*; #(
    parameter int unsigned n_addr = N_ADDR_DEF,
    parameter int unsigned n_bit  = N_BIT_DEF
) ();

    logic              Req_valid;
    logic              Req_ready;
    logic              Req_we;
    logic [2:0]        Funct3;
    logic [n_addr+1:0] Byte_addr;
    logic [n_bit-1:0]  Store_data;
    logic              Resp_valid;
    logic              Resp_err;
    logic [n_bit-1:0]  Load_data;
    logic [n_addr-1:0] Addr;
    logic [n_bit-1:0]  Wr_data;
    logic              MemRead;
    logic              MemWrite;
    logic [n_bit-1:0]  Rd_data;

    modport master (
        input  Req_valid, Req_we, Funct3, Byte_addr, Store_data, Rd_data,
        output Req_ready, Resp_valid, Resp_err, Load_data, Addr, Wr_data, MemRead, MemWrite
    );

    modport slave (
        output Req_valid, Req_we, Funct3, Byte_addr, Store_data, Rd_data,
        input  Req_ready, Resp_valid, Resp_err, Load_data, Addr, Wr_data, MemRead, MemWrite
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational alignment unit of the load/store controller.
//   we, funct3, lane : access kind and byte offset within the word
//   store_data       : store operand (low byte/half used for SB/SH)
//   rd_data          : word read from memory
//   load_val         : selected byte/half/word, sign- or zero-extended
//   merged           : rd_data with the store operand merged at the lane
//   err              : illegal funct3 or misaligned access
module lsu_align import rv_mem_defs::*; #(
    parameter int unsigned n_bit = N_BIT_DEF
) (
    input  logic             we,
    input  logic [2:0]       funct3,
    input  logic [1:0]       lane,
    input  logic [n_bit-1:0] store_data,
    input  logic [n_bit-1:0] rd_data,
    output logic [n_bit-1:0] load_val,
    output logic [n_bit-1:0] merged,
    output logic             err
);

    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    assign sel_b = rd_data[{lane, 3'b000} +: 8];
    assign sel_h = rd_data[{lane[1], 4'b0000} +: 16];

    always_comb begin
        load_val = '0;
        merged   = rd_data;
        err      = 1'b0;
        case (funct3)
            F3_B: begin
                load_val = {{(n_bit-8){sel_b[7]}}, sel_b};
                merged[{lane, 3'b000} +: 8] = store_data[7:0];
            end
            F3_H: begin
                err      = lane[0];
                load_val = {{(n_bit-16){sel_h[15]}}, sel_h};
                merged[{lane[1], 4'b0000} +: 16] = store_data[15:0];
            end
            F3_W: begin
                err      = (lane != 2'b00);
                load_val = rd_data;
                merged   = store_data;
            end
            // Unsigned variants exist only for loads.
            F3_BU: begin
                err      = we;
                load_val = {{(n_bit-8){1'b0}}, sel_b};
            end
            F3_HU: begin
                err      = we | lane[0];
                load_val = {{(n_bit-16){1'b0}}, sel_h};
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: turns byte-addressed RV32I loads/stores into word
// accesses on data_memory. Sub-word stores use read-modify-write.
//   Clk, Rst : clock, synchronous active-high reset
//   bus      : lsu_mem_ctrl_if.master (core request/response + memory bus)
module lsu_mem_ctrl import rv_mem_defs::*; #(
    parameter int unsigned n_addr = N_ADDR_DEF,
    parameter int unsigned n_bit  = N_BIT_DEF
) (
    input  logic           Clk,
    input  logic           Rst,
    lsu_mem_ctrl_if.master bus
);

    lsu_state_e        state_q, state_d;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [n_addr+1:0] baddr_q;
    logic [n_bit-1:0]  sdata_q;
    logic [n_bit-1:0]  wdata_q;
    logic [n_bit-1:0]  ldata_q;
    logic              err_q;

    logic              idle;
    logic              accept;
    logic              cap;
    logic              al_we;
    logic [2:0]        al_f3;
    logic [1:0]        al_lane;
    logic [n_bit-1:0]  al_load;
    logic [n_bit-1:0]  al_merged;
    logic              al_err;

    assign idle = (state_q == StIdle);

    // In IDLE the aligner judges the incoming request (error check at accept);
    // afterwards it works on the latched request for extract/merge in CAP.
    assign al_we   = idle ? bus.Req_we         : we_q;
    assign al_f3   = idle ? bus.Funct3         : f3_q;
    assign al_lane = idle ? bus.Byte_addr[1:0] : baddr_q[1:0];

    lsu_align #(
        .n_bit (n_bit)
    ) u_align (
        .we         (al_we),
        .funct3     (al_f3),
        .lane       (al_lane),
        .store_data (sdata_q),
        .rd_data    (bus.Rd_data),
        .load_val   (al_load),
        .merged     (al_merged),
        .err        (al_err)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        cap     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.Req_valid) begin
                    accept = 1'b1;
                    if (al_err) begin
                        state_d = StResp;
                    end else if (bus.Req_we && (bus.Funct3 == F3_W)) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd:   state_d = StCap;
            StCap: begin
                cap     = 1'b1;
                state_d = we_q ? StWr : StResp;
            end
            StWr:   state_d = StResp;
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.Req_ready  = idle;
        bus.MemRead    = (state_q == StRd);
        bus.MemWrite   = (state_q == StWr);
        bus.Resp_valid = (state_q == StResp);
        bus.Resp_err   = (state_q == StResp) & err_q;
        bus.Load_data  = (state_q == StResp) ? ldata_q : '0;
        bus.Addr       = baddr_q[n_addr+1:2];
        bus.Wr_data    = wdata_q;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            we_q    <= 1'b0;
            f3_q    <= '0;
            baddr_q <= '0;
            sdata_q <= '0;
            wdata_q <= '0;
            ldata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= bus.Req_we;
                f3_q    <= bus.Funct3;
                baddr_q <= bus.Byte_addr;
                sdata_q <= bus.Store_data;
                wdata_q <= bus.Store_data;
                ldata_q <= '0;
                err_q   <= al_err;
            end
            if (cap) begin
                if (we_q) begin
                    wdata_q <= al_merged;
                end else begin
                    ldata_q <= al_load;
                end
            end
        end
    end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store controller that sits between the core's execute stage and `data_memory` and acts as the initiator side of the memory interface. It drives `MemRead`, `MemWrite`, `Addr` and `Wr_data`, and consumes `Rd_data`. It turns RV32I byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses. Sub-word stores use a read-modify-write sequence; loads are extracted and sign- or zero-extended.

## Interface
Parameters:
- `n_addr`, default 8: word-address bits of `data_memory` (256 words).
- `n_bit`, default 32: data word width.

Ports:
- `Clk`  in  1  single clock; all state changes on its rising edge.
- `Rst`  in  1  reset, synchronous, active-high.
- `Req_valid`  in  1  core request strobe.
- `Req_ready`  out  1  high only in IDLE; a request is accepted when `Req_valid & Req_ready` at a rising edge.
- `Req_we`  in  1  1 = store, 0 = load.
- `Funct3`  in  3  RV32I funct3 of the access.
- `Byte_addr`  in  n_addr+2  byte address.
- `Store_data`  in  n_bit  store operand; only the low bits are used for SB/SH.
- `Resp_valid`  out  1  one-cycle completion pulse.
- `Resp_err`  out  1  valid with `Resp_valid`; high for a misaligned access or illegal funct3.
- `Load_data`  out  n_bit  extended load result, valid with `Resp_valid`; 0 for stores and errors.
- `Addr`  out  n_addr  word address to memory, equal to `Byte_addr[n_addr+1:2]`.
- `Wr_data`  out  n_bit  word written to memory.
- `MemRead`  out  1  memory read strobe.
- `MemWrite`  out  1  memory write strobe.
- `Rd_data`  in  n_bit  memory read data, valid the cycle after `MemRead` is high.

## Operation
- FSM states: IDLE, RD, CAP, WR, RESP.
- On accept, latch `Req_we`, `Funct3`, `Byte_addr` and `Store_data`.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: 000 SB, 001 SH, 010 SW.
- Misaligned accesses:
  - LH, LHU or SH with `addr[0]=1`.
  - LW or SW with `addr[1:0]≠0`.
- Error path: IDLE→RESP with `Resp_err=1`. `MemRead` and `MemWrite` are never asserted for an error request.
- Load path: IDLE→RD→CAP→RESP.
  - RD: `MemRead=1`.
  - CAP: latch `Rd_data`; select the byte or half by `addr[1:0]`; extend it (sign for LB/LH, zero for LBU/LHU).
- SW path: IDLE→WR→RESP. In WR, `MemWrite=1` and `Wr_data=Store_data`.
- SB/SH path: IDLE→RD→CAP→WR→RESP.
  - CAP merges `Store_data[7:0]` or `[15:0]` into the read word at byte lane `addr[1:0]`.
  - WR writes the merged word.
- RESP: `Resp_valid=1` for exactly one cycle, then return to IDLE. No backpressure is applied to responses.
- `MemRead` and `MemWrite` are never high in the same cycle.
- `Addr` is held constant from RD through WR.

## Timing
- Reset values: `Req_ready=1`; `Resp_valid`, `Resp_err`, `MemRead` and `MemWrite` = 0; `Load_data`, `Addr` and `Wr_data` = 0; state IDLE.
- Latency from the accept edge (cycle 0) to `Resp_valid`:
  - Error: cycle 1.
  - SW: cycle 2.
  - Load: cycle 3.
  - SB/SH: cycle 4.
- Throughput: next accept is possible on the edge that ends RESP+1. `Req_ready` is low from cycle 1 until back in IDLE.
- `Rst` mid-operation: the next edge forces IDLE and clears all strobes. An RMW that has reached RD or CAP issues no write.
- `Rst` in the same cycle as a request takes priority; the request is not accepted.
- Address wrap: the top byte address `2^(n_addr+2)-1` maps to word `2^n_addr-1`. No wrap logic exists; the address is truncated only.

## Structure
- Shared header/package `rv_mem_defs` holds:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - FSM state encodings;
  - `n_addr`/`n_bit` defaults.
- One combinational sub-module, `lsu_align`, performs:
  - load extract plus sign/zero-extend;
  - store lane merge;
  - misalign/illegal detection.
- `lsu_mem_ctrl` holds the FSM and registers only.

## Test plan
- SW `Byte_addr=0x24`, `Store_data=0x0002453E`: `MemWrite` high one cycle with `Addr=0x09`, `Wr_data=0x0002453E`; `Resp_valid` at cycle 2 with `Resp_err=0`.
- Memory word 9 = `0x80FF7F01`:
  - LB at 0x27 → `Load_data=0xFFFFFF80`;
  - LBU at 0x27 → `0x00000080`;
  - LH at 0x24 → `0x00007F01`;
  - LHU at 0x26 → `0x000080FF`;
  - each completes with `Resp_valid` at cycle 3.
- SB `Store_data=0xAB` at 0x25 with word 9 = `0x0001453E`: RD at cycle 1, then WR at cycle 3 with `Wr_data=0x0001AB3E`; `Resp_valid` at cycle 4.
- LW at 0x26, and Funct3=011: `Resp_valid` and `Resp_err` at cycle 1; `MemRead` and `MemWrite` stay 0; `Load_data=0`.
- SH at 0x24 with `Rst` pulsed while in CAP: no `MemWrite` pulse, state IDLE, `Req_ready=1` on the next cycle; memory word unchanged.
- Back-to-back SW then LW to the same address: the load returns the just-stored value. `Req_ready` is low during both operations and `Req_valid` held high is ignored.
